// File: rtl/ccff_prog_ctrl.sv
// ---------------------------------------------------------------------------
// ccff_prog_ctrl
//
// Programming controller for one tile's switch-block configuration chain
// (ccff_head -> ... -> ccff_tail). Bitstream words arrive on a valid/ready
// stream and are serialised MSB-first into the chain. A per-cycle shift
// enable drives the chain's clock-gate cell. The default length of 56 covers
// 4 x 8-bit size10 mux memories plus 4 x 6-bit size8 mux memories.
//
// Parameters
//   CHAIN_LEN  number of config flops in the chain (>= 1)
//   WORD_W     bitstream word width (>= 1)
//
// Ports
//   prog_clk        in   programming clock
//   pReset          in   asynchronous active-low reset
//   start           in   one-cycle pulse, honoured only in IDLE or DONE
//   cfg_data        in   bitstream word, MSB shifted first
//   cfg_valid       in   cfg_data valid
//   cfg_ready       out  word accepted this cycle when cfg_valid is high
//   ccff_head       out  serial bit into the chain (meaningful with shift_en)
//   chain_shift_en  out  chain flops capture on this prog_clk edge
//   ccff_tail       in   serial bit out of the chain
//   busy            out  programming in progress
//   done            out  chain fully loaded, held until the next start
//   error           out  verify mismatch, held with done
//
// Build option
//   CCFF_VERIFY_EN  when defined, a second pass re-shifts the same bitstream
//                   and compares ccff_tail against ccff_head on every shift;
//                   when undefined, a single pass runs and error is tied low.
// ---------------------------------------------------------------------------
module ccff_prog_ctrl #(
  parameter int CHAIN_LEN = 56,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);

  // Terminal counts are compared against the value before the increment,
  // so the decision is made in the cycle that shifts the final bit.
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   wbit_q, wbit_d;

`ifdef CCFF_VERIFY_EN
  logic pass_q, pass_d;
  logic err_q, err_d;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= S_IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      wbit_q    <= '0;
`ifdef CCFF_VERIFY_EN
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      wbit_q    <= wbit_d;
`ifdef CCFF_VERIFY_EN
      pass_q    <= pass_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    sreg_d         = sreg_q;
    bit_cnt_d      = bit_cnt_q;
    wbit_d         = wbit_q;
    cfg_ready      = 1'b0;
    chain_shift_en = 1'b0;
    ccff_head      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
`ifdef CCFF_VERIFY_EN
    pass_d         = pass_q;
    err_d          = err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
`ifdef CCFF_VERIFY_EN
        error = err_q && (state_q == S_DONE);
`endif
        if (start) begin
          state_d   = S_FETCH;
          bit_cnt_d = '0;
`ifdef CCFF_VERIFY_EN
          pass_d    = 1'b0;
          err_d     = 1'b0;
`endif
        end
      end

      S_FETCH: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_valid) begin
          sreg_d  = cfg_data;
          wbit_d  = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        chain_shift_en = 1'b1;
        busy           = 1'b1;
        ccff_head      = sreg_q[WORD_W-1];
        sreg_d         = sreg_q << 1;
        bit_cnt_d      = bit_cnt_q + CNT_W'(1);
        wbit_d         = wbit_q + WB_W'(1);
`ifdef CCFF_VERIFY_EN
        // After a full first pass the tail presents exactly the bit that is
        // being re-sent on the head, so any difference is a chain fault.
        if (pass_q && (ccff_tail != sreg_q[WORD_W-1])) begin
          err_d = 1'b1;
        end
`endif
        // Chain-full wins over word-end so the unused LSBs of a short
        // final word are simply dropped.
        if (bit_cnt_q == LAST_BIT) begin
`ifdef CCFF_VERIFY_EN
          if (!pass_q) begin
            pass_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else if (wbit_q == LAST_WBIT) begin
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccff_prog_ctrl
//
// Self-checking bench for ccff_prog_ctrl. A 56-flop instance is driven from a
// table of {word, valid gap, bits used} records; the bits expected on
// ccff_head are queued as each word is offered and popped on every shift.
// A second 13-flop instance covers the short-final-word case. Both chains
// are modelled as plain shift registers feeding ccff_tail back, so the
// CCFF_VERIFY_EN build sees a realistic tail stream.
// ---------------------------------------------------------------------------
module tb_ccff_prog_ctrl;

  localparam int CHAIN_LEN = 56;
  localparam int WORD_W    = 8;
  localparam int LEN13     = 13;
  localparam int BUDGET    = 40;
`ifdef CCFF_VERIFY_EN
  localparam int  NPASS      = 2;
  localparam logic VERIFY_ON = 1'b1;
`else
  localparam int  NPASS      = 1;
  localparam logic VERIFY_ON = 1'b0;
`endif

  typedef struct {
    logic [WORD_W-1:0] data;
    int                gap;
    int                exp_used;
  } vec_t;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              chain_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;

  logic              start13;
  logic [WORD_W-1:0] data13;
  logic              valid13;
  logic              ready13;
  logic              head13;
  logic              en13;
  logic              tail13;
  logic              busy13;
  logic              done13;
  logic              err13;

  logic [CHAIN_LEN-1:0] chain;
  logic [LEN13-1:0]     chain13;

  vec_t vecs[7];
  logic exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   shifts;
  int   busy_start_at;
  int   reset_at;
  int   corrupt_idx;
  logic aborted;
  logic start_armed;

  always #5 prog_clk = ~prog_clk;

  ccff_prog_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .chain_shift_en(chain_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  ccff_prog_ctrl #(.CHAIN_LEN(LEN13), .WORD_W(WORD_W)) dut13 (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start13),
    .cfg_data      (data13),
    .cfg_valid     (valid13),
    .cfg_ready     (ready13),
    .ccff_head     (head13),
    .chain_shift_en(en13),
    .ccff_tail     (tail13),
    .busy          (busy13),
    .done          (done13),
    .error         (err13)
  );

  // Behavioural configuration chains: capture on shift enable only.
  always @(posedge prog_clk) begin
    if (chain_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    if (en13) chain13 <= {chain13[LEN13-2:0], head13};
  end
  assign ccff_tail = chain[CHAIN_LEN-1];
  assign tail13    = chain13[LEN13-1];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One clock step, observed at the falling edge. Also acts as the output
  // monitor for the 56-flop instance and fires the mid-load injections.
  task automatic tick();
    logic e;
    @(negedge prog_clk);
    if (start_armed) begin
      start       = 1'b0;
      start_armed = 1'b0;
    end
    if (pReset && chain_shift_en) begin
      shifts++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_shift", chain_shift_en, 1'b0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("head_bit", ccff_head, e);
      end
      if (shifts == busy_start_at) begin
        start       = 1'b1;
        start_armed = 1'b1;
      end
      if (shifts == reset_at) begin
        #2 pReset = 1'b0;
        #1;
        checkOutput("rst_async_ready", cfg_ready, 1'b0);
        checkOutput("rst_async_shift", chain_shift_en, 1'b0);
        checkOutput("rst_async_head", ccff_head, 1'b0);
        checkOutput("rst_async_busy", busy, 1'b0);
        checkOutput("rst_async_done", done, 1'b0);
        checkOutput("rst_async_error", error, 1'b0);
        aborted = 1'b1;
      end
    end
  endtask

  task automatic pulseStart();
    start       = 1'b1;
    start_armed = 1'b1;
    tick();
  endtask

  // Offer one word: optionally hold valid low for v.gap cycles once the
  // controller is waiting, then queue the bits that should reach the chain.
  task automatic applyStimulus(input vec_t v);
    int t = 0;
    cfg_data  = v.data;
    cfg_valid = (v.gap == 0);
    while (!cfg_ready && t < BUDGET && !aborted) begin
      tick();
      t++;
    end
    if (aborted) return;
    if (!cfg_ready) begin
      checkOutput("ready_timeout", cfg_ready, 1'b1);
      return;
    end
    for (int g = 0; g < v.gap; g++) begin
      tick();
      if (aborted) return;
      checkOutput("gap_no_shift", chain_shift_en, 1'b0);
      checkOutput("gap_ready_held", cfg_ready, 1'b1);
    end
    cfg_valid = 1'b1;
    for (int b = 0; b < v.exp_used; b++) exp_q.push_back(v.data[WORD_W-1-b]);
    tick();
  endtask

  task automatic doLoad(input logic exp_err);
    vec_t v;
    int   k;
    shifts  = 0;
    aborted = 1'b0;
    for (int p = 0; p < NPASS; p++) begin
      for (int i = 0; i < 7; i++) begin
        if (aborted) return;
        v = vecs[i];
        if (p == 1 && i == corrupt_idx) v.data = 8'h80;
        applyStimulus(v);
      end
    end
    if (aborted) return;
    cfg_valid = 1'b0;
    k = 0;
    while (!done && k < BUDGET && !aborted) begin
      tick();
      k++;
    end
    if (aborted) return;
    checkOutput("done_latency", k, vecs[6].exp_used);
    checkOutput("shift_total", shifts, CHAIN_LEN * NPASS);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("busy_after_done", busy, 1'b0);
    checkOutput("ready_after_done", cfg_ready, 1'b0);
    checkOutput("error_after_done", error, exp_err);
  endtask

  task automatic runOddLength();
    logic [LEN13-1:0] bits13 = '0;
    int               cnt13  = 0;
    int               t;
    int               k;
    logic             seen_ready = 1'b0;
    start13 = 1'b1;
    tick();
    start13 = 1'b0;
    for (int p = 0; p < NPASS; p++) begin
      for (int w = 0; w < 2; w++) begin
        data13  = (w == 0) ? 8'hF0 : 8'hA8;
        valid13 = 1'b1;
        t = 0;
        while (!ready13 && t < BUDGET) begin
          tick();
          if (en13) begin bits13 = {bits13[LEN13-2:0], head13}; cnt13++; end
          t++;
        end
        checkOutput("odd_ready_seen", ready13, 1'b1);
        tick();
        if (en13) begin bits13 = {bits13[LEN13-2:0], head13}; cnt13++; end
      end
    end
    k = 0;
    while (!done13 && k < BUDGET) begin
      tick();
      if (en13) begin bits13 = {bits13[LEN13-2:0], head13}; cnt13++; end
      k++;
    end
    checkOutput("odd_done_latency", k, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready13) seen_ready = 1'b1;
    end
    valid13 = 1'b0;
    checkOutput("odd_head_stream", bits13, 13'b1111000010101);
    checkOutput("odd_shift_count", cnt13, LEN13 * NPASS);
    checkOutput("odd_no_third_ready", seen_ready, 1'b0);
    checkOutput("odd_done_held", done13, 1'b1);
    checkOutput("odd_error", err13, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 8};
    vecs[1] = '{8'h3C, 0, 8};
    vecs[2] = '{8'hFF, 0, 8};
    vecs[3] = '{8'h00, 0, 8};
    vecs[4] = '{8'h81, 0, 8};
    vecs[5] = '{8'h7E, 0, 8};
    vecs[6] = '{8'h96, 0, 8};

    pReset        = 1'b0;
    start         = 1'b0;
    cfg_data      = '0;
    cfg_valid     = 1'b0;
    start13       = 1'b0;
    data13        = '0;
    valid13       = 1'b0;
    chain         = '0;
    chain13       = '0;
    shifts        = 0;
    busy_start_at = -1;
    reset_at      = -1;
    corrupt_idx   = -1;
    aborted       = 1'b0;
    start_armed   = 1'b0;

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("reset_ready", cfg_ready, 1'b0);
    checkOutput("reset_shift_en", chain_shift_en, 1'b0);
    checkOutput("reset_head", ccff_head, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_error", error, 1'b0);
    pReset = 1'b1;

    $display("[TB] valid while idle is not accepted");
    cfg_data  = 8'h55;
    cfg_valid = 1'b1;
    repeat (4) tick();
    checkOutput("idle_ready", cfg_ready, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_shift_en", chain_shift_en, 1'b0);
    cfg_valid = 1'b0;

    $display("[TB] basic load");
    pulseStart();
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_ready", cfg_ready, 1'b1);
    doLoad(1'b0);

    $display("[TB] restart from done, backpressure load");
    pulseStart();
    checkOutput("restart_done_drop", done, 1'b0);
    checkOutput("restart_busy", busy, 1'b1);
    checkOutput("restart_ready", cfg_ready, 1'b1);
    vecs[2].gap = 5;
    doLoad(1'b0);
    vecs[2].gap = 0;

    $display("[TB] start while busy");
    pulseStart();
    busy_start_at = 20;
    doLoad(1'b0);
    busy_start_at = -1;

    $display("[TB] odd chain length");
    runOddLength();

    $display("[TB] reset mid-load");
    pulseStart();
    reset_at = 30;
    doLoad(1'b0);
    reset_at = -1;
    checkOutput("reset_hit", aborted, 1'b1);
    exp_q.delete();
    cfg_valid = 1'b1;
    repeat (3) tick();
    pReset = 1'b1;
    repeat (5) tick();
    checkOutput("post_reset_busy", busy, 1'b0);
    checkOutput("post_reset_ready", cfg_ready, 1'b0);
    checkOutput("post_reset_done", done, 1'b0);
    cfg_valid = 1'b0;
    pulseStart();
    doLoad(1'b0);

    if (VERIFY_ON) begin
      $display("[TB] verify pass with corrupted word");
      corrupt_idx = 3;
      pulseStart();
      doLoad(1'b1);
      corrupt_idx = -1;
      pulseStart();
      checkOutput("error_cleared_on_start", error, 1'b0);
      doLoad(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
